// File: rtl/fg_fetch_pkg.sv
// fg_fetch_pkg
// Shared configuration, types and address helper for the foreground fetch
// arbiter. The read path (pipeline requests) and the write path (capture
// FIFO) both form SRAM word addresses through pixel_addr(), so the two paths
// always agree on the frame layout.
//
// Contents:
//   PRECISION .. WR_FIFO_DEPTH   frame / bus geometry
//   fg_resp_t                    delay-line tag {valid, skip}
//   wr_entry_t                   queued SRAM write {addr, data}
//   pixel_addr(x, y)             y*FG_WIDTH + x, truncated to ADDR_WIDTH
package fg_fetch_pkg;

  localparam int PRECISION         = 11;
  localparam int PIXEL_SIZE        = 16;
  localparam int FG_WIDTH          = 800;
  localparam int FG_HEIGHT         = 600;
  localparam int ADDR_WIDTH        = 19;
  localparam int SRAM_READ_LATENCY = 1;
  localparam int WR_FIFO_DEPTH     = 4;

  // Bit width needed to hold FG_WIDTH itself; sets the multiplier width.
  localparam int FG_WIDTH_BITS = $clog2(FG_WIDTH + 1);
  localparam int PROD_WIDTH    = PRECISION + FG_WIDTH_BITS;

  localparam logic [PRECISION-1:0]     FG_WIDTH_P  = PRECISION'(FG_WIDTH);
  localparam logic [PRECISION-1:0]     FG_HEIGHT_P = PRECISION'(FG_HEIGHT);
  localparam logic [FG_WIDTH_BITS-1:0] FG_WIDTH_M  = FG_WIDTH_BITS'(FG_WIDTH);

  typedef struct packed {
    logic valid;
    logic skip;
  } fg_resp_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [PIXEL_SIZE-1:0] data;
  } wr_entry_t;

  // Callers must bounds-check first; the result is simply truncated.
  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [PRECISION-1:0] x,
                                                       input logic [PRECISION-1:0] y);
    logic [PROD_WIDTH-1:0] prod;
    prod = PROD_WIDTH'(y) * PROD_WIDTH'(FG_WIDTH_M);
    prod = prod + PROD_WIDTH'(x);
    return prod[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fg_fetch_arbiter_if.sv
// fg_fetch_arbiter_if
// Bundles the arbiter's three buses: the pixel-pipeline request/response
// pair, the capture-path write port, and the single-ported SRAM.
//
// Modports:
//   slave   the arbiter itself (takes requests/writes, drives the SRAM)
//   master  the surrounding environment (pipeline, capture path, SRAM)
//
// Signals:
//   fg_pixel_request_x/y/active   signed request coordinate + valid
//   fg_pixel_in/skip/ready        response pixel, out-of-bounds flag, valid
//   wr_x/wr_y/wr_data/wr_valid    capture write offer
//   wr_ready                      write accepted when high with wr_valid
//   ctrl_fg_freeze                drop new writes while high
//   sram_addr/wdata/we/oe/rdata   registered SRAM bus
//   overrun_count                 write back-pressure cycle counter
interface fg_fetch_arbiter_if;
  import fg_fetch_pkg::*;

  logic signed [PRECISION:0]  fg_pixel_request_x;
  logic signed [PRECISION:0]  fg_pixel_request_y;
  logic                       fg_pixel_request_active;
  logic [PIXEL_SIZE-1:0]      fg_pixel_in;
  logic                       fg_pixel_skip;
  logic                       fg_pixel_ready;

  logic [PRECISION-1:0]       wr_x;
  logic [PRECISION-1:0]       wr_y;
  logic [PIXEL_SIZE-1:0]      wr_data;
  logic                       wr_valid;
  logic                       wr_ready;
  logic                       ctrl_fg_freeze;

  logic [ADDR_WIDTH-1:0]      sram_addr;
  logic [PIXEL_SIZE-1:0]      sram_wdata;
  logic                       sram_we;
  logic                       sram_oe;
  logic [PIXEL_SIZE-1:0]      sram_rdata;

  logic [15:0]                overrun_count;

  modport slave (
    input  fg_pixel_request_x, fg_pixel_request_y, fg_pixel_request_active,
    output fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
    input  wr_x, wr_y, wr_data, wr_valid, ctrl_fg_freeze,
    output wr_ready,
    output sram_addr, sram_wdata, sram_we, sram_oe,
    input  sram_rdata,
    output overrun_count
  );

  modport master (
    output fg_pixel_request_x, fg_pixel_request_y, fg_pixel_request_active,
    input  fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
    output wr_x, wr_y, wr_data, wr_valid, ctrl_fg_freeze,
    input  wr_ready,
    input  sram_addr, sram_wdata, sram_we, sram_oe,
    output sram_rdata,
    input  overrun_count
  );

endinterface

// File: rtl/fg_write_fifo.sv
// fg_write_fifo
// Small synchronous FIFO holding pending foreground SRAM writes. The head
// entry is presented combinationally (show-ahead) so the arbiter can issue
// it in the same cycle it decides to pop.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        write push_data this cycle
//   push_data   {addr, data} entry
//   pop         retire the head entry this cycle
//   head        current head entry (valid only when !empty)
//   full/empty  occupancy flags derived from the registered count
module fg_write_fifo
  import fg_fetch_pkg::*;
#(
  parameter int DEPTH = WR_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A push while full is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/fg_fetch_arbiter.sv
// fg_fetch_arbiter
// Foreground memory front-end ahead of the pixel pipeline. Signed pipeline
// requests become SRAM reads (or skips when off-frame) and come back exactly
// FOREGROUND_FETCH_CYCLE_DELAY cycles later with no stall path. Cycles with
// no in-bounds read drain one entry of the capture write FIFO. Reads always
// win the single SRAM port.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   fg    fg_fetch_arbiter_if.slave (request/response, write port, SRAM)
//
// Build option:
//   FG_FETCH_OVERRUN_CNT_EN  when defined, fg.overrun_count counts cycles
//                            with wr_valid && !wr_ready, saturating at
//                            16'hFFFF; otherwise it is tied to zero.
module fg_fetch_arbiter
  import fg_fetch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fg_fetch_arbiter_if.slave fg
);

  localparam int FOREGROUND_FETCH_CYCLE_DELAY = SRAM_READ_LATENCY + 2;
  // Delay-line stage that lines up with sram_rdata being valid.
  localparam int DATA_TAP = SRAM_READ_LATENCY;

  logic                  rd_in_bounds;
  logic                  rd_go;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_in_bounds;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  wr_entry_t             fifo_in;
  wr_entry_t             fifo_head;
  fg_resp_t              delay_line [FOREGROUND_FETCH_CYCLE_DELAY];

  // Address stage: bounds checks and address formation for both paths.
  // A negative coordinate shows up as the sign bit, so the magnitude compare
  // only needs the low PRECISION bits.
  always_comb begin
    rd_in_bounds = !fg.fg_pixel_request_x[PRECISION] &&
                   (fg.fg_pixel_request_x[PRECISION-1:0] < FG_WIDTH_P) &&
                   !fg.fg_pixel_request_y[PRECISION] &&
                   (fg.fg_pixel_request_y[PRECISION-1:0] < FG_HEIGHT_P);
    rd_go        = fg.fg_pixel_request_active && rd_in_bounds;
    rd_addr      = pixel_addr(fg.fg_pixel_request_x[PRECISION-1:0],
                              fg.fg_pixel_request_y[PRECISION-1:0]);
    wr_in_bounds = (fg.wr_x < FG_WIDTH_P) && (fg.wr_y < FG_HEIGHT_P);
    // Off-frame or frozen writes are still handshaken, just never queued.
    fifo_push    = fg.wr_valid && !fifo_full && !fg.ctrl_fg_freeze && wr_in_bounds;
    // Any cycle without an in-bounds read is a write slot, skips included.
    fifo_pop     = !rd_go && !fifo_empty;
    fifo_in.addr = pixel_addr(fg.wr_x, fg.wr_y);
    fifo_in.data = fg.wr_data;
  end

  assign fg.wr_ready = !fifo_full;

  fg_write_fifo #(
    .DEPTH(WR_FIFO_DEPTH)
  ) u_write_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // SRAM command register. Address and write data hold their last value on
  // idle cycles so the bus does not toggle needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg.sram_addr  <= '0;
      fg.sram_wdata <= '0;
      fg.sram_we    <= 1'b0;
      fg.sram_oe    <= 1'b0;
    end else begin
      fg.sram_we <= 1'b0;
      fg.sram_oe <= 1'b0;
      if (rd_go) begin
        fg.sram_oe   <= 1'b1;
        fg.sram_addr <= rd_addr;
      end else if (fifo_pop) begin
        fg.sram_we    <= 1'b1;
        fg.sram_addr  <= fifo_head.addr;
        fg.sram_wdata <= fifo_head.data;
      end
    end
  end

  // Fixed-latency tag pipeline: every request, hit or skip, yields exactly
  // one response at the far end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FOREGROUND_FETCH_CYCLE_DELAY; i++) delay_line[i] <= '0;
    end else begin
      delay_line[0] <= '{valid: fg.fg_pixel_request_active,
                         skip:  fg.fg_pixel_request_active && !rd_in_bounds};
      for (int i = 1; i < FOREGROUND_FETCH_CYCLE_DELAY; i++) delay_line[i] <= delay_line[i-1];
    end
  end

  assign fg.fg_pixel_ready = delay_line[FOREGROUND_FETCH_CYCLE_DELAY-1].valid;
  assign fg.fg_pixel_skip  = delay_line[FOREGROUND_FETCH_CYCLE_DELAY-1].skip;

  // Capture read data one stage before the response leaves; skips and empty
  // slots force the pixel to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg.fg_pixel_in <= '0;
    end else if (delay_line[DATA_TAP].valid && !delay_line[DATA_TAP].skip) begin
      fg.fg_pixel_in <= fg.sram_rdata;
    end else begin
      fg.fg_pixel_in <= '0;
    end
  end

`ifdef FG_FETCH_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  // Saturating count of cycles the capture path was back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= '0;
    end else if (fg.wr_valid && fifo_full && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign fg.overrun_count = overrun_q;
`else
  assign fg.overrun_count = '0;
`endif

endmodule

// File: tb/tb_fg_fetch_arbiter.sv
// tb_fg_fetch_arbiter
// Directed bench for fg_fetch_arbiter. Stimulus pushes expected responses,
// expected SRAM read addresses and expected SRAM writes into queues; an
// independent monitor pops them whenever the DUT shows a response, an
// sram_oe or an sram_we. A behavioural SRAM with one cycle read latency
// answers the reads.
module tb_fg_fetch_arbiter;
  import fg_fetch_pkg::*;

`ifdef FG_FETCH_OVERRUN_CNT_EN
  localparam int EXP_OVERRUN = 4;
`else
  localparam int EXP_OVERRUN = 0;
`endif
  localparam int RESP_LATENCY = 3;
  localparam int MEM_WORDS    = 1 << ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fg_fetch_arbiter_if bus ();

  fg_fetch_arbiter dut (
    .clk (clk),
    .rst (rst),
    .fg  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        skip;
    logic [15:0] pixel;
    int          cyc;
  } exp_resp_t;

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
  } exp_wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          started  = 1'b0;

  exp_resp_t   exp_resp  [$];
  logic [18:0] exp_raddr [$];
  exp_wr_t     exp_wr    [$];
  exp_resp_t   mon_resp;
  exp_wr_t     mon_wr;
  logic [18:0] mon_raddr;

  logic [15:0] preload   [int];
  logic [15:0] sram_mem  [MEM_WORDS];
  logic        sram_wr   [MEM_WORDS];

  // Cycle counter used to time-stamp requests and responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: written words override preloaded ones; unknown
  // addresses read back as DEAD.
  always @(posedge clk) begin
    if (bus.sram_we) begin
      sram_mem[int'(bus.sram_addr)] <= bus.sram_wdata;
      sram_wr[int'(bus.sram_addr)]  <= 1'b1;
    end
    if (bus.sram_oe) begin
      if (sram_wr[int'(bus.sram_addr)])
        bus.sram_rdata <= sram_mem[int'(bus.sram_addr)];
      else if (preload.exists(int'(bus.sram_addr)))
        bus.sram_rdata <= preload[int'(bus.sram_addr)];
      else
        bus.sram_rdata <= 16'hDEAD;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compare every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      if (bus.fg_pixel_ready) begin
        checkOutput("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
        if (exp_resp.size() != 0) begin
          mon_resp = exp_resp.pop_front();
          checkOutput("resp_skip", 32'(bus.fg_pixel_skip), 32'(mon_resp.skip));
          checkOutput("resp_pixel", 32'(bus.fg_pixel_in), 32'(mon_resp.pixel));
          checkOutput("resp_latency", 32'(cyc - mon_resp.cyc), 32'(RESP_LATENCY));
        end
      end
      if (bus.sram_oe) begin
        checkOutput("oe_we_exclusive", 32'(bus.sram_we), 32'd0);
        checkOutput("read_expected", 32'(exp_raddr.size() != 0), 32'd1);
        if (exp_raddr.size() != 0) begin
          mon_raddr = exp_raddr.pop_front();
          checkOutput("read_addr", 32'(bus.sram_addr), 32'(mon_raddr));
        end
      end
      if (bus.sram_we) begin
        checkOutput("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          mon_wr = exp_wr.pop_front();
          checkOutput("write_addr", 32'(bus.sram_addr), 32'(mon_wr.addr));
          checkOutput("write_data", 32'(bus.sram_wdata), 32'(mon_wr.data));
        end
      end
    end
  end

  // Drive one request for one cycle; expected address/data are hand-computed.
  task automatic applyStimulus(input int x, input int y, input logic [18:0] a,
                               input logic [15:0] d, input bit skip);
    exp_resp_t e;
    @(posedge clk);
    #1;
    bus.fg_pixel_request_x      = 12'(x);
    bus.fg_pixel_request_y      = 12'(y);
    bus.fg_pixel_request_active = 1'b1;
    if (!skip) begin
      preload[int'(a)] = d;
      exp_raddr.push_back(a);
    end
    e.skip  = skip;
    e.pixel = skip ? 16'h0000 : d;
    e.cyc   = cyc;
    exp_resp.push_back(e);
  endtask

  task automatic driveWrite(input int x, input int y, input logic [15:0] d);
    bus.wr_x     = 11'(x);
    bus.wr_y     = 11'(y);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
  endtask

  task automatic expectWrite(input logic [18:0] a, input logic [15:0] d);
    exp_wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic idleCycles(input int n);
    @(posedge clk);
    #1;
    bus.fg_pixel_request_active = 1'b0;
    bus.wr_valid                = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pixel_in"}, 32'(bus.fg_pixel_in), 32'd0);
    checkOutput({tag, "_skip"}, 32'(bus.fg_pixel_skip), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.fg_pixel_ready), 32'd0);
    checkOutput({tag, "_sram_addr"}, 32'(bus.sram_addr), 32'd0);
    checkOutput({tag, "_sram_wdata"}, 32'(bus.sram_wdata), 32'd0);
    checkOutput({tag, "_sram_we"}, 32'(bus.sram_we), 32'd0);
    checkOutput({tag, "_sram_oe"}, 32'(bus.sram_oe), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(bus.overrun_count), 32'd0);
    checkOutput({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
  endtask

  // Fill-test vectors: reads (x, y, addr, data) and writes (x, y, addr, data).
  int          rd_x [8] = '{0, 799, 0, 5, 799, 0, 100, 321};
  int          rd_y [8] = '{0, 0, 1, 1, 599, 599, 10, 123};
  logic [18:0] rd_a [8] = '{19'd0, 19'd799, 19'd800, 19'd805, 19'd479999, 19'd479200, 19'd8100, 19'd98721};
  logic [15:0] rd_d [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
  int          wr_xt [8] = '{1, 0, 799, 20, 7, 8, 9, 10};
  int          wr_yt [8] = '{0, 1, 599, 3, 7, 7, 7, 7};
  logic [18:0] wr_at [4] = '{19'd1, 19'd800, 19'd479999, 19'd2420};
  logic [15:0] wr_dt [8] = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 16'hE006, 16'hE007, 16'hE008};

  initial begin
    bus.fg_pixel_request_x      = '0;
    bus.fg_pixel_request_y      = '0;
    bus.fg_pixel_request_active = 1'b0;
    bus.wr_x                    = '0;
    bus.wr_y                    = '0;
    bus.wr_data                 = '0;
    bus.wr_valid                = 1'b0;
    bus.ctrl_fg_freeze          = 1'b0;
    bus.sram_rdata              = '0;
    for (int i = 0; i < MEM_WORDS; i++) sram_wr[i] = 1'b0;

    // Power-on reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    started = 1'b1;
    @(negedge clk);
    checkResetValues("reset");

    // Single in-bounds read: (10,2) -> 2*800+10 = 1610.
    applyStimulus(10, 2, 19'd1610, 16'hABCD, 1'b0);
    idleCycles(6);

    // Off-frame requests on each boundary produce back-to-back skips.
    applyStimulus(-1, 0, 19'd0, 16'h0000, 1'b1);
    applyStimulus(800, 5, 19'd0, 16'h0000, 1'b1);
    applyStimulus(0, 600, 19'd0, 16'h0000, 1'b1);
    idleCycles(6);

    // Off-frame writes are accepted and dropped; (3,0) lands at address 3.
    @(posedge clk); #1; driveWrite(800, 0, 16'h0BAD);
    @(negedge clk); checkOutput("oob_wr_ready_x", 32'(bus.wr_ready), 32'd1);
    @(posedge clk); #1; driveWrite(0, 600, 16'h0BAD);
    @(negedge clk); checkOutput("oob_wr_ready_y", 32'(bus.wr_ready), 32'd1);
    @(posedge clk); #1; driveWrite(3, 0, 16'h0C0C); expectWrite(19'd3, 16'h0C0C);
    @(negedge clk); checkOutput("inb_wr_ready", 32'(bus.wr_ready), 32'd1);
    idleCycles(5);

    // Eight back-to-back reads with writes offered every cycle: the FIFO
    // takes four, then back-pressures; no write reaches the SRAM meanwhile.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(rd_x[i], rd_y[i], rd_a[i], rd_d[i], 1'b0);
      driveWrite(wr_xt[i], wr_yt[i], wr_dt[i]);
      if (i < 4) expectWrite(wr_at[i], wr_dt[i]);
      @(negedge clk);
      checkOutput("fill_wr_ready", 32'(bus.wr_ready), 32'(i < 4));
      checkOutput("fill_no_we", 32'(bus.sram_we), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.fg_pixel_request_active = 1'b0;
    bus.wr_valid                = 1'b0;
    // The last read issues this cycle, then four writes drain back to back.
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checkOutput("drain_we", 32'(bus.sram_we), 32'((j >= 1) && (j <= 4)));
    end
    checkOutput("overrun_count", 32'(bus.overrun_count), 32'(EXP_OVERRUN));
    checkOutput("drained_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Read back two drained writes.
    applyStimulus(0, 1, 19'd800, 16'hB002, 1'b0);
    applyStimulus(799, 599, 19'd479999, 16'hC003, 1'b0);
    idleCycles(6);

    // Freeze: writes handshake but never reach the SRAM.
    bus.ctrl_fg_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      driveWrite(30 + i, 4, 16'h7770 + 16'(i));
      @(negedge clk);
      checkOutput("freeze_wr_ready", 32'(bus.wr_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("freeze_no_we", 32'(bus.sram_we), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ctrl_fg_freeze = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("freeze_fifo_empty", 32'(bus.sram_we), 32'd0);
    end

    // Reset one cycle after a request with a write queued: the read strobe
    // still appears, but no response and no write survive.
    @(posedge clk);
    #1;
    bus.fg_pixel_request_x      = 12'd5;
    bus.fg_pixel_request_y      = 12'd1;
    bus.fg_pixel_request_active = 1'b1;
    preload[805] = 16'h4444;
    exp_raddr.push_back(19'd805);
    driveWrite(2, 0, 16'hF00F);
    @(posedge clk);
    #1;
    bus.fg_pixel_request_active = 1'b0;
    bus.wr_valid                = 1'b0;
    rst                         = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    repeat (6) begin
      @(negedge clk);
      checkOutput("midreset_no_ready", 32'(bus.fg_pixel_ready), 32'd0);
      checkOutput("midreset_no_we", 32'(bus.sram_we), 32'd0);
    end

    // Every expected event must have been consumed within a bounded wait.
    for (int i = 0; i < 20; i++) begin
      if (exp_resp.size() + exp_raddr.size() + exp_wr.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("queues_drained", 32'(exp_resp.size() + exp_raddr.size() + exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
